// File: rtl/seq_detect_deser_pkg.sv
// Shared definitions for seq_detect_deser: detector state encoding and
// default widths for the deserializer word and the match counter.
package seq_detect_deser_pkg;

  localparam int unsigned WORD_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned ST_W       = 3;

  // Raw state codes; FOUND_H is the "match already reported" copy of FOUND.
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_GOT1    = 3'd1;
  localparam logic [ST_W-1:0] ST_GOT10   = 3'd2;
  localparam logic [ST_W-1:0] ST_GOT101  = 3'd3;
  localparam logic [ST_W-1:0] ST_FOUND   = 3'd4;
  localparam logic [ST_W-1:0] ST_FOUND_H = 3'd5;

  typedef enum logic [ST_W-1:0] {
    IDLE    = ST_IDLE,
    GOT1    = ST_GOT1,
    GOT10   = ST_GOT10,
    GOT101  = ST_GOT101,
    FOUND   = ST_FOUND,
    FOUND_H = ST_FOUND_H
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky overflow flag and synchronous clear.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of count and overflow (wins over inc)
//   inc        : count one event
//   cnt        : current count, saturates at all-ones
//   ovf        : set by an event arriving while cnt is all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count / overflow
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/seq_detect_deser.sv
// Serial "1011" detector (overlapping, Moore) running side by side with a
// WORD_W-bit serial-to-parallel deserializer on the same EN-qualified bits.
// Ports:
//   CLK, RST   : clock, async active-low reset
//   Din, EN    : serial bit and its valid qualifier
//   CLR        : synchronous clear of Match_cnt / Overflow only
//   Match      : one-cycle pulse per detected pattern
//   Match_cnt  : saturating detection count; Overflow: sticky saturation hit
//   Word       : last WORD_W sampled bits, newest in LSB
//   Word_valid : one-cycle pulse when Word completes
module seq_detect_deser
  import seq_detect_deser_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Din,
  input  logic              EN,
  input  logic              CLR,
  output logic              Match,
  output logic [CNT_W-1:0]  Match_cnt,
  output logic              Overflow,
  output logic [WORD_W-1:0] Word,
  output logic              Word_valid
);

  localparam int unsigned     BC_W    = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  state_e            state_q, state_d;
  logic              match_q, match_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              wv_q, wv_d;

  // Detector next state; FOUND always leaves after one cycle so Match pulses once
  always_comb begin
    state_d = state_q;
    if (EN) begin
      case (state_q)
        IDLE:          state_d = Din ? GOT1   : IDLE;
        GOT1:          state_d = Din ? GOT1   : GOT10;
        GOT10:         state_d = Din ? GOT101 : IDLE;
        GOT101:        state_d = Din ? FOUND  : GOT10;
        FOUND, FOUND_H: state_d = Din ? GOT1  : GOT10;
        default:       state_d = IDLE;
      endcase
    end else if (state_q == FOUND) begin
      state_d = FOUND_H;
    end
    // FOUND is only ever entered from GOT101, so this is also the count event
    match_d = (state_d == FOUND);
  end

  // Deserializer shift register and bit counter
  always_comb begin
    word_d = word_q;
    bc_d   = bc_q;
    wv_d   = 1'b0;
    if (EN) begin
      word_d = {word_q[WORD_W-2:0], Din};
      bc_d   = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);
      wv_d   = (bc_q == BC_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      word_q  <= '0;
      bc_q    <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      word_q  <= word_d;
      bc_q    <= bc_d;
      wv_q    <= wv_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (CLR),
    .inc   (match_d),
    .cnt   (Match_cnt),
    .ovf   (Overflow)
  );

  assign Match      = match_q;
  assign Word       = word_q;
  assign Word_valid = wv_q;

endmodule

// File: tb/tb_seq_detect_deser.sv
// Scoreboard bench for seq_detect_deser (WORD_W=8, CNT_W=2): directed bit
// streams push expected Match / Word events; a negedge monitor compares.
module tb_seq_detect_deser;

  logic       clk = 1'b0;
  logic       rst, din, en, clr;
  logic       match, ovf, word_valid;
  logic [1:0] match_cnt;
  logic [7:0] word;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct { int edge_no; int cnt; int ovf; } m_t;
  typedef struct { int edge_no; int w; } w_t;
  m_t mq[$];
  w_t wq[$];

  seq_detect_deser #(.WORD_W(8), .CNT_W(2)) dut (
    .CLK(clk), .RST(rst), .Din(din), .EN(en), .CLR(clr),
    .Match(match), .Match_cnt(match_cnt), .Overflow(ovf),
    .Word(word), .Word_valid(word_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  // Expectations refer to the next rising edge; called at a negedge.
  task automatic push_m(input int c, input int o);
    m_t e; e.edge_no = cyc + 1; e.cnt = c; e.ovf = o; mq.push_back(e);
  endtask

  task automatic push_w(input int w);
    w_t e; e.edge_no = cyc + 1; e.w = w; wq.push_back(e);
  endtask

  // All drive tasks start and end at a negedge.
  task automatic send(input logic b, input logic c = 1'b0);
    en = 1'b1; din = b; clr = c;
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_cnt"}, int'(match_cnt), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_word"}, int'(word), 0);
    chk({tag, "_wvalid"}, int'(word_valid), 0);
  endtask

  // Monitor: any pulse or any due expectation triggers a comparison
  always @(negedge clk) begin
    m_t me;
    w_t we;
    logic exp_m, exp_w;
    exp_m = (mq.size() > 0) && (mq[0].edge_no <= cyc);
    if (exp_m || match) begin
      chk("match_pulse", int'(match), int'(exp_m));
      if (exp_m) begin
        me = mq.pop_front();
        chk("match_edge", cyc, me.edge_no);
        chk("match_cnt", int'(match_cnt), me.cnt);
        chk("overflow", int'(ovf), me.ovf);
      end
    end
    exp_w = (wq.size() > 0) && (wq[0].edge_no <= cyc);
    if (exp_w || word_valid) begin
      chk("word_valid", int'(word_valid), int'(exp_w));
      if (exp_w) begin
        we = wq.pop_front();
        chk("word_edge", cyc, we.edge_no);
        chk("word", int'(word), we.w);
      end
    end
  end

  initial begin
    rst = 1'b0; din = 1'b0; en = 1'b0; clr = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);

    // Single pattern
    do_reset();
    send(1); send(0); send(1); push_m(1, 0); send(1);
    idle(2);

    // Overlapping patterns, pulses 3 edges apart
    do_reset();
    send(1); send(0); send(1); push_m(1, 0); send(1);
    send(0); send(1); push_m(2, 0); send(1);
    idle(2);

    // EN gap mid-pattern
    do_reset();
    send(1); send(0); send(1);
    idle(3);
    push_m(1, 0); send(1);
    idle(2);

    // Saturation, overflow, CLR racing a detection; words B6 and DB
    do_reset();
    send(1); send(0); send(1); push_m(1, 0); send(1);
    send(0); send(1); push_m(2, 0); send(1);
    push_w(8'hB6); send(0);
    send(1); push_m(3, 0); send(1);
    send(0); send(1); push_m(3, 1); send(1);
    send(0); send(1); push_m(0, 0); push_w(8'hDB); send(1, 1'b1);
    send(0); send(1); push_m(1, 0); send(1);
    idle(1);
    chk("cnt_before_clr", int'(match_cnt), 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("cnt_after_clr", int'(match_cnt), 0);
    chk("ovf_after_clr", int'(ovf), 0);

    // Word A6, then a word with EN gaps 8 edges later
    do_reset();
    send(1); send(0); send(1); send(0); send(0); send(1); send(1);
    push_w(8'hA6); send(0);
    idle(2);
    chk("word_stable", int'(word), 8'hA6);
    send(0); send(0); send(0); send(0);
    idle(3);
    send(1); send(1); send(1);
    push_w(8'h0F); send(1);
    idle(2);

    // Async reset mid-pattern and mid-word
    do_reset();
    send(1); send(0); send(1); push_m(1, 0); send(1);
    send(1); send(0); send(1);
    chk("pre_reset_cnt", int'(match_cnt), 1);
    #1 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    send(1); send(1); send(0); send(0); send(0); send(0); send(0);
    push_w(8'hC0); send(0);
    idle(3);

    chk("match_queue_empty", mq.size(), 0);
    chk("word_queue_empty", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_deser.md
SEQ_DETECT_DESER -- requirements
Module: seq_detect_deser

Interface
REQ-001 Parameter WORD_W, default 8: deserializer word width in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match counter width in bits, legal range 2..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 Din  input  1  serial data bit, consumed from the upstream DFF stage output.
REQ-006 EN  input  1  bit-valid qualifier; Din is sampled only on edges where EN=1.
REQ-007 CLR  input  1  synchronous clear of Match_cnt and Overflow.
REQ-008 Match  output  1  high for exactly one cycle per detected "1011" (Moore, registered).
REQ-009 Match_cnt  output  CNT_W  number of detections since reset/CLR, saturating.
REQ-010 Overflow  output  1  sticky flag: a detection occurred while Match_cnt was all-ones.
REQ-011 Word  output  WORD_W  last WORD_W sampled bits; newest bit in LSB.
REQ-012 Word_valid  output  1  one-cycle pulse when Word holds a freshly completed word.

Function
REQ-013 Detector SHALL be a Moore FSM with states IDLE, GOT1, GOT10, GOT101, FOUND, recognizing "1011" (first bit received first), with overlap allowed.
REQ-014 Transitions on EN=1, as Din=0/Din=1: IDLE->IDLE/GOT1; GOT1->GOT10/GOT1; GOT10->IDLE/GOT101; GOT101->GOT10/FOUND; FOUND->GOT10/GOT1.
REQ-015 On EN=0 the FSM SHALL hold its state, except FOUND, which SHALL advance to a holding copy so that Match never stays high for more than one cycle.
REQ-016 Match SHALL be 1 only in the cycle directly after the edge that samples the 4th pattern bit (latency 1 cycle).
REQ-017 Match_cnt SHALL increment by 1 on each FSM entry into FOUND and SHALL saturate at 2^CNT_W-1.
REQ-018 An entry into FOUND while Match_cnt is saturated SHALL set Overflow; Overflow SHALL stay at 1 until CLR or reset.
REQ-019 CLR=1 SHALL set Match_cnt and Overflow to 0 on the next edge; when CLR and an increment coincide, CLR wins (result 0).
REQ-020 CLR SHALL NOT affect the FSM state, Word, or the bit counter.
REQ-021 On each EN=1 edge: Word <= {Word[WORD_W-2:0], Din}, and the bit counter (0..WORD_W-1) increments, wrapping to 0.
REQ-022 The edge that samples the bit with counter = WORD_W-1 SHALL assert Word_valid for the following cycle only.
REQ-023 Word SHALL remain stable between EN=1 edges.
REQ-024 Detector and deserializer SHALL operate concurrently on the same sampled bit, with no interaction.

Reset
REQ-025 While RST=0: FSM=IDLE, Match=0, Match_cnt=0, Overflow=0, Word=0, bit counter=0, Word_valid=0, applied immediately and independent of CLK.
REQ-026 Reset asserted mid-pattern or mid-word SHALL discard the partial pattern or partial word.
REQ-027 After release, the first EN=1 edge SHALL be treated as bit 0 of both the pattern and the word.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (3-bit localparams) and the default WORD_W and CNT_W values.
REQ-029 The saturating counter with sticky overflow SHALL be one sub-module, sat_counter, parameterized by CNT_W.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 EN=1, Din stream 1,0,1,1 after reset -> Match=1 for one cycle after the 4th edge; Match_cnt=1.
REQ-032 Din stream 1,0,1,1,0,1,1 -> two Match pulses, 3 cycles apart (overlap); Match_cnt=2.
REQ-033 Din stream 1,0,1 / EN=0 for 3 cycles / Din 1 -> one Match, 1 cycle after the final EN edge; no Match while EN=0.
REQ-034 CNT_W=2, five detections -> Match_cnt=3 and Overflow=1 after the 4th detection; then CLR coincident with a detection -> Match_cnt=0, Overflow=0.
REQ-035 WORD_W=8, bits 1,0,1,0,0,1,1,0 -> Word=8'hA6 with Word_valid high for one cycle; the next word pulses Word_valid exactly 8 EN edges later.
REQ-036 RST=0 asserted between clock edges after bits 1,0,1 -> all outputs 0 immediately; after release, stream 1,1 produces no Match.
